// File: rtl/uart_tx_frame_seq.sv
// uart_tx_frame_seq: streams result words to a uart_tx as sync byte, MSB-first payload and XOR checksum.
module uart_tx_frame_seq #(
  parameter int NUM_WORDS = 4,
  parameter int WORD_BYTES = 4,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic                    i_Clock,
  input  logic                    i_Reset,
  input  logic [8*WORD_BYTES-1:0] i_Word,
  input  logic                    i_Word_Valid,
  output logic                    o_Word_Ready,
  input  logic                    i_Tx_Active,
  input  logic                    i_Tx_Done,
  output logic                    o_Tx_DV,
  output logic [7:0]              o_Tx_Byte,
  output logic                    o_Busy,
  output logic                    o_Frame_Done
);
  localparam int W = 8 * WORD_BYTES;
  localparam int BW = $clog2(WORD_BYTES + 1);
  localparam int CW = NUM_WORDS > 1 ? $clog2(NUM_WORDS) : 1;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACT, WAIT_DONE, WAIT_CLR, NEXT, LOAD} state_t;
  state_t state, state_nx;
  logic [W-1:0] word;
  logic [7:0] cks;
  logic [CW-1:0] word_cnt;
  logic [BW-1:0] byte_cnt;
  logic sync, cks_sent, xfer, more, last_word;
  assign more = sync || byte_cnt != BW'(WORD_BYTES);
  assign last_word = word_cnt == CW'(NUM_WORDS - 1);
  assign xfer = i_Word_Valid && o_Word_Ready;
  assign o_Tx_DV = state == ISSUE;
  assign o_Busy = state != IDLE;
  always_ff @(posedge i_Clock)
    if (i_Reset) state <= IDLE;
    else state <= state_nx;
  // IDLE waits for the transmitter to go quiet so a reset mid-byte never stacks a launch on it
  always_comb begin
    state_nx = state;
    o_Word_Ready = 1'b0;
    o_Frame_Done = 1'b0;
    case (state)
      IDLE: begin
        o_Word_Ready = !i_Reset && !i_Tx_Active && !i_Tx_Done;
        state_nx = i_Word_Valid && o_Word_Ready ? ISSUE : IDLE;
      end
      ISSUE:     state_nx = WAIT_ACT;
      WAIT_ACT:  state_nx = i_Tx_Active ? WAIT_DONE : WAIT_ACT;
      WAIT_DONE: state_nx = i_Tx_Done ? WAIT_CLR : WAIT_DONE;
      WAIT_CLR:  state_nx = !i_Tx_Done && !i_Tx_Active ? NEXT : WAIT_CLR;
      NEXT: begin
        state_nx = more ? ISSUE : !last_word ? LOAD : !cks_sent ? ISSUE : IDLE;
        o_Frame_Done = !i_Reset && !more && last_word && cks_sent;
      end
      LOAD: begin
        o_Word_Ready = !i_Reset;
        state_nx = i_Word_Valid && !i_Reset ? NEXT : LOAD;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge i_Clock)
    if (i_Reset) begin
      word <= '0;
      cks <= '0;
      word_cnt <= '0;
      byte_cnt <= '0;
      sync <= 1'b0;
      cks_sent <= 1'b0;
      o_Tx_Byte <= '0;
    end else if (state == IDLE && xfer) begin
      word <= i_Word;
      cks <= '0;
      word_cnt <= '0;
      byte_cnt <= '0;
      sync <= 1'b1;
      cks_sent <= 1'b0;
      o_Tx_Byte <= SYNC_BYTE;
    end else if (state == LOAD && xfer) begin
      word <= i_Word;
    end else if (state == NEXT) begin
      if (more) begin
        o_Tx_Byte <= word[W-1 -: 8];
        word <= word << 8;
        cks <= cks ^ word[W-1 -: 8];
        byte_cnt <= byte_cnt + 1'b1;
        sync <= 1'b0;
      end else if (!last_word) begin
        word_cnt <= word_cnt + 1'b1;
        byte_cnt <= '0;
      end else if (!cks_sent) begin
        o_Tx_Byte <= cks;
        cks_sent <= 1'b1;
      end
    end
endmodule

// File: tb/tb_uart_tx_frame_seq.sv
// tb_uart_tx_frame_seq: directed checks of two sequencer configs against a behavioural uart_tx.
module tb_uart_tx_frame_seq;
  localparam int CPB = 12;
  localparam int BYTE_CLKS = 10 * CPB;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [15:0] word_a = '0;
  logic [7:0] word_b = '0;
  logic valid [2] = '{1'b0, 1'b0};
  logic ready [2];
  logic tx_dv [2];
  logic [7:0] tx_byte [2];
  logic busy [2];
  logic fdone [2];
  logic tx_act [2] = '{1'b0, 1'b0};
  logic tx_done [2] = '{1'b0, 1'b0};
  int cnt [2];
  int dcnt [2];
  logic [7:0] cur [2];
  logic [7:0] logb [2][64];
  int logn [2];
  int dvn [2];
  int viol [2];
  int fdn [2];
  logic [9:0] frm0;
  logic line0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_frame_seq #(.NUM_WORDS(2), .WORD_BYTES(2), .SYNC_BYTE(8'hA5)) dut_a (
    .i_Clock(clk), .i_Reset(rst), .i_Word(word_a), .i_Word_Valid(valid[0]),
    .o_Word_Ready(ready[0]), .i_Tx_Active(tx_act[0]), .i_Tx_Done(tx_done[0]),
    .o_Tx_DV(tx_dv[0]), .o_Tx_Byte(tx_byte[0]), .o_Busy(busy[0]), .o_Frame_Done(fdone[0]));

  uart_tx_frame_seq #(.NUM_WORDS(1), .WORD_BYTES(1), .SYNC_BYTE(8'hA5)) dut_b (
    .i_Clock(clk), .i_Reset(rst), .i_Word(word_b), .i_Word_Valid(valid[1]),
    .o_Word_Ready(ready[1]), .i_Tx_Active(tx_act[1]), .i_Tx_Done(tx_done[1]),
    .o_Tx_DV(tx_dv[1]), .o_Tx_Byte(tx_byte[1]), .o_Busy(busy[1]), .o_Frame_Done(fdone[1]));

  // Transmitter model: no reset, active for 10 bit times, then done high for 2 cycles
  always @(posedge clk)
    for (int i = 0; i < 2; i++) begin
      if (fdone[i]) fdn[i] <= fdn[i] + 1;
      if (tx_dv[i]) begin
        dvn[i] <= dvn[i] + 1;
        if (tx_act[i] || tx_done[i]) viol[i] <= viol[i] + 1;
        else begin
          tx_act[i] <= 1'b1;
          cnt[i] <= BYTE_CLKS;
          cur[i] <= tx_byte[i];
          if (logn[i] < 64) logb[i][logn[i]] <= tx_byte[i];
          logn[i] <= logn[i] + 1;
        end
      end
      if (tx_act[i]) begin
        if (cnt[i] == 1) begin
          tx_act[i] <= 1'b0;
          tx_done[i] <= 1'b1;
          dcnt[i] <= 2;
        end else cnt[i] <= cnt[i] - 1;
      end
      if (tx_done[i]) begin
        if (dcnt[i] == 1) tx_done[i] <= 1'b0;
        dcnt[i] <= dcnt[i] - 1;
      end
    end

  always_comb begin
    frm0 = {1'b1, cur[0], 1'b0};
    line0 = tx_act[0] ? frm0[(BYTE_CLKS - cnt[0]) / CPB] : 1'b1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push(input int i, input logic [15:0] w, output bit ok);
    @(negedge clk);
    if (i == 0) word_a = w;
    else word_b = w[7:0];
    valid[i] = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (ready[i]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    valid[i] = 1'b0;
  endtask

  task automatic wait_frame(input int i, output bit ok);
    int start;
    start = fdn[i];
    ok = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (fdn[i] != start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks += 6;
    if (tx_dv[0] !== 1'b0) begin errors++; $display("FAIL reset_dv: got %b want 0", tx_dv[0]); end
    if (tx_byte[0] !== 8'h00) begin errors++; $display("FAIL reset_byte: got %h want 00", tx_byte[0]); end
    if (busy[0] !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy[0]); end
    if (fdone[0] !== 1'b0) begin errors++; $display("FAIL reset_fdone: got %b want 0", fdone[0]); end
    if (ready[0] !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", ready[0]); end
    if (busy[1] !== 1'b0) begin errors++; $display("FAIL reset_busy_b: got %b want 0", busy[1]); end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ready[0] !== 1'b1) begin errors++; $display("FAIL idle_ready: got %b want 1", ready[0]); end
  endtask

  task automatic test_frame;
    logic [7:0] exp [6] = '{8'hA5, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    int base, d0, f0;
    bit ok;
    base = logn[0];
    d0 = dvn[0];
    f0 = fdn[0];
    push(0, 16'h1234, ok);
    checks += 3;
    if (!ok) begin errors++; $display("FAIL frame_push0: ready never seen"); end
    if (tx_dv[0] !== 1'b1) begin errors++; $display("FAIL latency_dv: got %b want 1", tx_dv[0]); end
    if (tx_byte[0] !== 8'hA5) begin errors++; $display("FAIL sync_byte: got %h want a5", tx_byte[0]); end
    push(0, 16'hABCD, ok);
    wait_frame(0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL frame_done_timeout: no frame done"); end
    @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (logb[0][base+k] !== exp[k]) begin
        errors++;
        $display("FAIL frame_byte%0d: got %h want %h", k, logb[0][base+k], exp[k]);
      end
    end
    checks += 3;
    if (dvn[0] - d0 != 6) begin errors++; $display("FAIL frame_dv_count: got %0d want 6", dvn[0] - d0); end
    if (fdn[0] - f0 != 1) begin errors++; $display("FAIL frame_done_count: got %0d want 1", fdn[0] - f0); end
    if (busy[0] !== 1'b0) begin errors++; $display("FAIL frame_busy_after: got %b want 0", busy[0]); end
  endtask

  task automatic test_stall;
    int base, d0, bad_r, bad_dv, bad_line;
    bit ok;
    base = logn[0];
    bad_r = 0;
    bad_dv = 0;
    bad_line = 0;
    push(0, 16'h1234, ok);
    ok = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (ready[0]) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL stall_load_timeout: LOAD never reached"); end
    d0 = dvn[0];
    repeat (500) begin
      @(negedge clk);
      if (ready[0] !== 1'b1) bad_r++;
      if (tx_dv[0] !== 1'b0) bad_dv++;
      if (line0 !== 1'b1) bad_line++;
    end
    checks += 4;
    if (bad_r != 0) begin errors++; $display("FAIL stall_ready: %0d low cycles, want 0", bad_r); end
    if (bad_dv != 0) begin errors++; $display("FAIL stall_dv: %0d dv cycles, want 0", bad_dv); end
    if (bad_line != 0) begin errors++; $display("FAIL stall_line: %0d non-idle cycles, want 0", bad_line); end
    if (dvn[0] != d0) begin errors++; $display("FAIL stall_dv_count: got %0d want %0d", dvn[0], d0); end
    push(0, 16'hABCD, ok);
    wait_frame(0, ok);
    checks += 3;
    if (!ok) begin errors++; $display("FAIL stall_frame_timeout: no frame done"); end
    if (logb[0][base+3] !== 8'hAB) begin errors++; $display("FAIL stall_resume_byte: got %h want ab", logb[0][base+3]); end
    if (logb[0][base+5] !== 8'h40) begin errors++; $display("FAIL stall_checksum: got %h want 40", logb[0][base+5]); end
  endtask

  task automatic test_checksum_reset;
    int base;
    bit ok;
    base = logn[0];
    push(0, 16'h00FF, ok);
    push(0, 16'h00FF, ok);
    wait_frame(0, ok);
    push(0, 16'h0102, ok);
    push(0, 16'h0304, ok);
    wait_frame(0, ok);
    checks += 4;
    if (!ok) begin errors++; $display("FAIL cks_frame_timeout: no frame done"); end
    if (logn[0] - base != 12) begin errors++; $display("FAIL cks_byte_count: got %0d want 12", logn[0] - base); end
    if (logb[0][base+5] !== 8'h00) begin errors++; $display("FAIL cks_frame1: got %h want 00", logb[0][base+5]); end
    if (logb[0][base+11] !== 8'h04) begin errors++; $display("FAIL cks_frame2: got %h want 04", logb[0][base+11]); end
  endtask

  task automatic test_mid_reset;
    logic [7:0] exp [6] = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
    int base, f0, bad_r;
    bit ok;
    f0 = fdn[0];
    bad_r = 0;
    base = logn[0];
    push(0, 16'h1234, ok);
    ok = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (logn[0] == base + 2 && tx_act[0]) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL mid_payload_timeout: payload byte not seen"); end
    word_a = 16'h0102;
    valid[0] = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks += 5;
    if (tx_dv[0] !== 1'b0) begin errors++; $display("FAIL mid_dv: got %b want 0", tx_dv[0]); end
    if (tx_byte[0] !== 8'h00) begin errors++; $display("FAIL mid_byte: got %h want 00", tx_byte[0]); end
    if (busy[0] !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b want 0", busy[0]); end
    if (fdone[0] !== 1'b0) begin errors++; $display("FAIL mid_fdone: got %b want 0", fdone[0]); end
    if (ready[0] !== 1'b0) begin errors++; $display("FAIL mid_ready: got %b want 0", ready[0]); end
    base = logn[0];
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if ((tx_act[0] || tx_done[0]) && ready[0]) bad_r++;
      if (ready[0]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks += 2;
    if (!ok) begin errors++; $display("FAIL mid_ready_timeout: ready never returned"); end
    if (bad_r != 0) begin errors++; $display("FAIL mid_ready_gating: %0d early cycles, want 0", bad_r); end
    @(posedge clk);
    #1;
    valid[0] = 1'b0;
    push(0, 16'h0304, ok);
    wait_frame(0, ok);
    checks += 2;
    if (!ok) begin errors++; $display("FAIL mid_frame_timeout: no frame done"); end
    if (fdn[0] - f0 != 1) begin errors++; $display("FAIL mid_fdone_count: got %0d want 1", fdn[0] - f0); end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (logb[0][base+k] !== exp[k]) begin
        errors++;
        $display("FAIL mid_byte%0d: got %h want %h", k, logb[0][base+k], exp[k]);
      end
    end
  endtask

  task automatic test_single;
    logic [7:0] exp [3] = '{8'hA5, 8'h5A, 8'h5A};
    int base;
    bit ok;
    base = logn[1];
    push(1, 16'h005A, ok);
    wait_frame(1, ok);
    checks += 2;
    if (!ok) begin errors++; $display("FAIL single_timeout: no frame done"); end
    if (logn[1] - base != 3) begin errors++; $display("FAIL single_count: got %0d want 3", logn[1] - base); end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (logb[1][base+k] !== exp[k]) begin
        errors++;
        $display("FAIL single_byte%0d: got %h want %h", k, logb[1][base+k], exp[k]);
      end
    end
  endtask

  task automatic test_dv_pacing;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks += 2;
      if (viol[i] != 0) begin errors++; $display("FAIL pacing_dv_busy%0d: got %0d want 0", i, viol[i]); end
      if (dvn[i] != logn[i]) begin errors++; $display("FAIL pacing_dropped%0d: dv %0d sent %0d", i, dvn[i], logn[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_stall();
    test_checksum_reset();
    test_mid_reset();
    test_single();
    test_dv_pacing();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
